// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared state encoding and sizing helpers for the LUT config loader
package lut_cfg_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;
    typedef enum logic [1:0] {ST_IDLE = IDLE, ST_LOAD = LOAD, ST_ERR = ERR} state_e;
    function automatic int beats(input int width, input int chunk);
        return width / chunk;
    endfunction
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/lut_cfg_parity_check.sv
// lut_cfg_parity_check: flags whether a config beat matches its even-parity bit
module lut_cfg_parity_check #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] cfg_data_i,
    input  logic             cfg_parity_i,
    output logic             parity_ok_o
);
    assign parity_ok_o = (^cfg_data_i) == cfg_parity_i;
endmodule

// File: rtl/lut_config_loader.sv
// lut_config_loader: assembles a LUT mask from chunked beats; optional LUT_CONFIG_PARITY_EN adds beat parity checking
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int WIDTH  = 1 << INPUTS,
    parameter int CHUNK  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [CHUNK-1:0] cfg_data,
    input  logic             cfg_valid,
`ifdef LUT_CONFIG_PARITY_EN
    input  logic             cfg_parity,
    output logic             cfg_error,
`endif
    output logic             cfg_ready,
    output logic [WIDTH-1:0] values,
    output logic             lut_enable,
    output logic             busy,
    output logic             done
);
    localparam int BEATS = beats(WIDTH, CHUNK);
    localparam int CW    = clog2_min1(BEATS);

    state_e           state_q;
    logic [CW-1:0]    beat_cnt_q;
    logic [WIDTH-1:0] values_q;
    logic             lut_enable_q, cfg_ready_q, busy_q, done_q;
    logic             parity_ok, accept, last;

`ifdef LUT_CONFIG_PARITY_EN
    logic cfg_error_q;
    lut_cfg_parity_check #(.CHUNK(CHUNK)) u_parity (
        .cfg_data_i  (cfg_data),
        .cfg_parity_i(cfg_parity),
        .parity_ok_o (parity_ok)
    );
    assign cfg_error = cfg_error_q;
`else
    assign parity_ok = 1'b1;
`endif

    assign accept     = cfg_valid && cfg_ready_q;
    assign last       = beat_cnt_q == CW'(BEATS - 1);
    assign cfg_ready  = cfg_ready_q;
    assign values     = values_q;
    assign lut_enable = lut_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Load FSM: abort beats everything, a bad beat goes to ERR, the last good beat publishes the mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            values_q     <= '0;
            lut_enable_q <= 1'b0;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LUT_CONFIG_PARITY_EN
            cfg_error_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (cfg_start) begin
                    state_q      <= ST_LOAD;
                    beat_cnt_q   <= '0;
                    lut_enable_q <= 1'b0;
                    cfg_ready_q  <= 1'b1;
                    busy_q       <= 1'b1;
                end
                ST_LOAD: if (cfg_abort) begin
                    state_q     <= ST_IDLE;
                    beat_cnt_q  <= '0;
                    cfg_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end else if (accept && !parity_ok) begin
                    state_q     <= ST_ERR;
                    cfg_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
`ifdef LUT_CONFIG_PARITY_EN
                    cfg_error_q <= 1'b1;
`endif
                end else if (accept) begin
                    values_q[beat_cnt_q*CHUNK +: CHUNK] <= cfg_data;
                    if (last) begin
                        state_q      <= ST_IDLE;
                        beat_cnt_q   <= '0;
                        cfg_ready_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        lut_enable_q <= 1'b1;
                        done_q       <= 1'b1;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
`ifdef LUT_CONFIG_PARITY_EN
                ST_ERR: if (cfg_start) begin
                    state_q     <= ST_LOAD;
                    beat_cnt_q  <= '0;
                    cfg_ready_q <= 1'b1;
                    busy_q      <= 1'b1;
                    cfg_error_q <= 1'b0;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader: directed and randomized checks of the loader against a beat-level mask model
module tb_lut_config_loader;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_valid = 1'b0;
    logic [3:0]  cfg_data = 4'h0;
    logic        cfg_ready, lut_enable, busy, done;
    logic [15:0] values;
`ifdef LUT_CONFIG_PARITY_EN
    logic        cfg_parity = 1'b0;
    logic        cfg_error;
    bit          m_err;
`endif
    int          checks = 0, errors = 0;
    bit          m_load, m_en, m_done;
    int          m_n;
    logic [15:0] m_values;

    lut_config_loader #(.INPUTS(4), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
`ifdef LUT_CONFIG_PARITY_EN
        .cfg_parity(cfg_parity),
        .cfg_error (cfg_error),
`endif
        .cfg_ready (cfg_ready),
        .values    (values),
        .lut_enable(lut_enable),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_n = 0; m_values = '0; m_en = 0; m_done = 0;
`ifdef LUT_CONFIG_PARITY_EN
        m_err = 0;
`endif
    endtask

    task automatic compare(input string tag);
        check({tag, ".values"}, 32'(values), 32'(m_values));
        check({tag, ".lut_enable"}, 32'(lut_enable), 32'(m_en));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".busy"}, 32'(busy), 32'(m_load));
        check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(m_load));
`ifdef LUT_CONFIG_PARITY_EN
        check({tag, ".cfg_error"}, 32'(cfg_error), 32'(m_err));
`endif
    endtask

    // Apply inputs, advance the model by one accepted/ignored beat, clock, then compare
    task automatic drive(input string tag, input bit s, input bit a, input bit v, input logic [3:0] d, input bit pb);
        bit bad;
        cfg_start = s; cfg_abort = a; cfg_valid = v; cfg_data = d;
        bad = 0;
`ifdef LUT_CONFIG_PARITY_EN
        cfg_parity = (^d) ^ pb;
        bad = pb;
`else
        if (pb) bad = 0;
`endif
        m_done = 0;
        if (!m_load) begin
            if (s) begin
                m_load = 1; m_n = 0; m_en = 0;
`ifdef LUT_CONFIG_PARITY_EN
                m_err = 0;
`endif
            end
        end else if (a) begin
            m_load = 0;
        end else if (v && bad) begin
            m_load = 0;
`ifdef LUT_CONFIG_PARITY_EN
            m_err = 1;
`endif
        end else if (v) begin
            m_values[m_n*4 +: 4] = d;
            m_n++;
            if (m_n == 4) begin
                m_load = 0; m_en = 1; m_done = 1;
            end
        end
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic load_word(input string tag, input logic [15:0] w);
        drive(tag, 1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++) drive(tag, 0, 0, 1, w[i*4 +: 4], 0);
    endtask

    initial begin
        model_reset();
        #1;
        compare("reset_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare("reset");

        load_word("t1", 16'h4321);
        check("t1_values", 32'(values), 32'h4321);
        check("t1_enable", 32'(lut_enable), 1);
        check("t1_done", 32'(done), 1);
        drive("t1_after", 0, 0, 0, 4'h0, 0);
        check("t1_done_pulse", 32'(done), 0);

        drive("t2", 1, 0, 0, 4'h0, 0);
        drive("t2", 0, 0, 1, 4'h1, 0);
        drive("t2", 0, 0, 1, 4'h2, 0);
        for (int i = 0; i < 3; i++) begin
            drive("t2_stall", 0, 0, 0, 4'(i + 9), 0);
            check("t2_busy", 32'(busy), 1);
        end
        drive("t2", 0, 0, 1, 4'h3, 0);
        drive("t2", 0, 0, 1, 4'h4, 0);
        check("t2_values", 32'(values), 32'h4321);

        load_word("t3_fill", 16'hFFFF);
        drive("t3", 1, 0, 0, 4'h0, 0);
        drive("t3", 0, 0, 1, 4'h0, 0);
        drive("t3", 0, 0, 1, 4'h0, 0);
        drive("t3_abort", 0, 1, 0, 4'h0, 0);
        check("t3_values", 32'(values), 32'hFF00);
        check("t3_enable", 32'(lut_enable), 0);
        drive("t3_idle", 0, 0, 1, 4'h7, 0);
        check("t3_no_done", 32'(done), 0);

        drive("t4", 1, 0, 0, 4'h0, 0);
        drive("t4", 0, 0, 1, 4'h1, 0);
        drive("t4", 0, 0, 1, 4'h2, 0);
        drive("t4", 0, 0, 1, 4'h3, 0);
        drive("t4_abort_last", 0, 1, 1, 4'hA, 0);
        check("t4_values", 32'(values), 32'hF321);
        check("t4_enable", 32'(lut_enable), 0);
        check("t4_idle", 32'(busy), 0);

        drive("t5", 1, 0, 0, 4'h0, 0);
        drive("t5", 0, 0, 1, 4'h5, 0);
        drive("t5", 0, 0, 1, 4'h6, 0);
        rst = 1'b1;
        #1;
        check("t5_values", 32'(values), 0);
        check("t5_ready", 32'(cfg_ready), 0);
        check("t5_enable", 32'(lut_enable), 0);
        model_reset();
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare("t5_post");

`ifdef LUT_CONFIG_PARITY_EN
        drive("t6", 1, 0, 0, 4'h0, 0);
        drive("t6_bad", 0, 0, 1, 4'h3, 1);
        check("t6_error", 32'(cfg_error), 1);
        check("t6_ready", 32'(cfg_ready), 0);
        check("t6_values", 32'(values), 0);
        drive("t6_clear", 1, 0, 0, 4'h0, 0);
        check("t6_cleared", 32'(cfg_error), 0);
`endif

        for (int i = 0; i < 400; i++) begin
            drive("rand", ($urandom % 6) == 0, ($urandom % 20) == 0, ($urandom % 3) != 0,
                  4'($urandom), ($urandom % 25) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
